// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
// Holds the fetch FSM states and AXI encodings.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA,
    DRAIN
  } state_e;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] RESP_OKAY  = 2'b00;

  function automatic logic [2:0] size_log2(input int nbytes);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if ((1 << i) == nbytes) r = i[2:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Multi-lane-push, single-pop instruction FIFO with flush.
// Full/empty come from registered pointers carrying a wrap bit.
module fetch_fifo #(
  parameter int WIDTH = 96,
  parameter int DEPTH = 32,
  parameter int LANES = 2,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        flush_i,
  input  logic [LANES-1:0]            push_i,
  input  logic [LANES-1:0][WIDTH-1:0] push_data_i,
  input  logic                        pop_i,
  output logic [WIDTH-1:0]            pop_data_o,
  output logic                        empty_o,
  output logic [AW:0]                 free_count_o
);

  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr_q;
  logic [AW:0]      rptr_q;
  logic [AW:0]      count;
  logic [AW:0]      n_push;
  logic [AW-1:0]    widx [LANES];

  assign count        = wptr_q - rptr_q;
  assign empty_o      = (count == '0);
  assign free_count_o = DEPTH_W - count;
  assign pop_data_o   = empty_o ? '0 : mem[rptr_q[AW-1:0]];

  // Pack the valid lanes contiguously after the write pointer.
  always_comb begin
    n_push = '0;
    for (int i = 0; i < LANES; i++) begin
      widx[i] = wptr_q[AW-1:0] + n_push[AW-1:0];
      n_push  = n_push + {{AW{1'b0}}, push_i[i]};
    end
  end

  // Storage write; a flush discards the same-cycle push.
  always_ff @(posedge clk) begin
    for (int i = 0; i < LANES; i++) begin
      if (push_i[i] && !flush_i) mem[widx[i]] <= push_data_i[i];
    end
  end

  // Pointer update; flush wins over a coincident push or pop.
  always_ff @(posedge clk) begin
    if (reset || flush_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_q + n_push;
      if (pop_i && !empty_o) rptr_q <= rptr_q + 1'b1;
    end
  end

endmodule

// File: rtl/axi_fetch_unit.sv
// AXI instruction-fetch front end: line bursts, beat splitter,
// instruction FIFO and redirect/drain handling.
module axi_fetch_unit #(
  parameter int ID_WIDTH   = 13,
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64,
  parameter int BURST_LEN  = 8,
  parameter int FIFO_DEPTH = 32,
  parameter int FETCH_ID   = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [63:0]           entry,
  input  logic                  redirect_valid,
  input  logic [63:0]           redirect_pc,
  output logic [ID_WIDTH-1:0]   m_axi_arid,
  output logic [ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [7:0]            m_axi_arlen,
  output logic [2:0]            m_axi_arsize,
  output logic [1:0]            m_axi_arburst,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  input  logic [DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rlast,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready,
  output logic                  inst_valid,
  input  logic                  inst_ready,
  output logic [31:0]           inst,
  output logic [63:0]           inst_pc,
  output logic                  fetch_fault
);
  import fetch_pkg::*;

  localparam int LPB   = DATA_WIDTH / 32;
  localparam int BYTES = DATA_WIDTH / 8;
  localparam int LINE  = BURST_LEN * BYTES;
  localparam int SLOTS = BURST_LEN * LPB;
  localparam int AW    = $clog2(FIFO_DEPTH);

  localparam logic [63:0] LINE_W    = 64'(LINE);
  localparam logic [63:0] LINE_MASK = ~(LINE_W - 64'd1);
  localparam logic [AW:0] SLOTS_W   = (AW+1)'(SLOTS);

  state_e      state_q, state_d;
  logic [63:0] fpc_q, fpc_d;
  logic [63:0] araddr_q, araddr_d;
  logic [7:0]  beat_q, beat_d;
  logic        fault_q, fault_d;
  logic        pend_q, pend_d;

  logic [63:0]               redir_pc;
  logic [63:0]               beat_base;
  logic                      beat_ok;
  logic [LPB-1:0]            push;
  logic [LPB-1:0][95:0]      push_data;
  logic [95:0]               pop_data;
  logic                      empty;
  logic [AW:0]               free_count;

  assign redir_pc  = redirect_pc & ~64'h3;
  assign beat_ok   = (m_axi_rresp == RESP_OKAY);
  assign beat_base = araddr_q + ({56'b0, beat_q} * 64'(BYTES));

  assign m_axi_arid    = ID_WIDTH'(FETCH_ID);
  assign m_axi_araddr  = araddr_q[ADDR_WIDTH-1:0];
  assign m_axi_arlen   = 8'(BURST_LEN - 1);
  assign m_axi_arsize  = size_log2(BYTES);
  assign m_axi_arburst = BURST_INCR;
  assign m_axi_arvalid = (state_q == ADDR);
  assign m_axi_rready  = (state_q == DATA) || (state_q == DRAIN);

  assign inst_valid  = !empty;
  assign inst        = pop_data[95:64];
  assign inst_pc     = pop_data[63:0];
  assign fetch_fault = fault_q;

  // Split a beat into instructions; drop those below the fetch PC.
  always_comb begin
    for (int i = 0; i < LPB; i++) begin
      logic [63:0] pc;
      pc           = beat_base + 64'(4 * i);
      push_data[i] = {m_axi_rdata[32*i +: 32], pc};
      push[i]      = (state_q == DATA) && m_axi_rvalid && !fault_q &&
                     beat_ok && !redirect_valid && (pc >= fpc_q);
    end
  end

  // Next-state logic for the fetch FSM and its address registers.
  always_comb begin
    state_d  = state_q;
    fpc_d    = fpc_q;
    araddr_d = araddr_q;
    beat_d   = beat_q;
    fault_d  = fault_q;
    pend_d   = pend_q;
    if (redirect_valid) begin
      fpc_d   = redir_pc;
      fault_d = 1'b0;
    end
    unique case (state_q)
      IDLE: begin
        if (!redirect_valid && !fault_q && free_count >= SLOTS_W) begin
          state_d  = ADDR;
          araddr_d = fpc_q & LINE_MASK;
        end
      end
      ADDR: begin
        if (redirect_valid) pend_d = 1'b1;
        if (m_axi_arready) begin
          beat_d  = '0;
          pend_d  = 1'b0;
          state_d = (pend_q || redirect_valid) ? DRAIN : DATA;
        end
      end
      DATA: begin
        if (m_axi_rvalid) begin
          beat_d = beat_q + 8'd1;
          if (!beat_ok && !redirect_valid) fault_d = 1'b1;
          if (m_axi_rlast) begin
            if (redirect_valid) begin
              state_d  = ADDR;
              araddr_d = redir_pc & LINE_MASK;
            end else begin
              state_d = IDLE;
              if (!fault_q && beat_ok) fpc_d = araddr_q + LINE_W;
            end
          end else if (redirect_valid) begin
            state_d = DRAIN;
          end
        end else if (redirect_valid) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (m_axi_rvalid && m_axi_rlast) begin
          state_d  = ADDR;
          araddr_d = (redirect_valid ? redir_pc : fpc_q) & LINE_MASK;
        end
      end
    endcase
  end

  // FSM and address state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      fpc_q    <= entry & ~64'h3;
      araddr_q <= '0;
      beat_q   <= '0;
      fault_q  <= 1'b0;
      pend_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      fpc_q    <= fpc_d;
      araddr_q <= araddr_d;
      beat_q   <= beat_d;
      fault_q  <= fault_d;
      pend_q   <= pend_d;
    end
  end

  fetch_fifo #(
    .WIDTH (96),
    .DEPTH (FIFO_DEPTH),
    .LANES (LPB)
  ) u_fifo (
    .clk          (clk),
    .reset        (reset),
    .flush_i      (redirect_valid),
    .push_i       (push),
    .push_data_i  (push_data),
    .pop_i        (inst_valid && inst_ready),
    .pop_data_o   (pop_data),
    .empty_o      (empty),
    .free_count_o (free_count)
  );

endmodule

// File: tb/tb_axi_fetch_unit.sv
// Directed bench for axi_fetch_unit with a small AXI read slave.
// Instruction word at address a is a[31:0] ^ 32'h13579BDF.
module tb_axi_fetch_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [63:0] entry = 64'h0;
  logic        redirect_valid = 1'b0;
  logic [63:0] redirect_pc = 64'h0;
  logic [12:0] m_axi_arid;
  logic [63:0] m_axi_araddr;
  logic [7:0]  m_axi_arlen;
  logic [2:0]  m_axi_arsize;
  logic [1:0]  m_axi_arburst;
  logic        m_axi_arvalid;
  logic        m_axi_arready;
  logic [63:0] m_axi_rdata;
  logic [1:0]  m_axi_rresp;
  logic        m_axi_rlast;
  logic        m_axi_rvalid;
  logic        m_axi_rready;
  logic        inst_valid;
  logic        inst_ready = 1'b1;
  logic [31:0] inst;
  logic [63:0] inst_pc;
  logic        fetch_fault;

  int checks = 0;
  int errors = 0;

  logic        ar_rdy = 1'b1;
  int          err_beat = -1;
  logic [63:0] s_base;
  logic [7:0]  s_beat;
  logic [63:0] s_addr;

  logic [63:0] ar_q [$];
  logic [63:0] pc_q [$];
  logic [31:0] in_q [$];

  always #5 clk = ~clk;

  axi_fetch_unit dut (
    .clk            (clk),
    .reset          (reset),
    .entry          (entry),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .m_axi_arid     (m_axi_arid),
    .m_axi_araddr   (m_axi_araddr),
    .m_axi_arlen    (m_axi_arlen),
    .m_axi_arsize   (m_axi_arsize),
    .m_axi_arburst  (m_axi_arburst),
    .m_axi_arvalid  (m_axi_arvalid),
    .m_axi_arready  (m_axi_arready),
    .m_axi_rdata    (m_axi_rdata),
    .m_axi_rresp    (m_axi_rresp),
    .m_axi_rlast    (m_axi_rlast),
    .m_axi_rvalid   (m_axi_rvalid),
    .m_axi_rready   (m_axi_rready),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .fetch_fault    (fetch_fault)
  );

  function automatic logic [31:0] memf(input logic [63:0] a);
    return a[31:0] ^ 32'h1357_9BDF;
  endfunction

  // AXI read slave: 8-beat bursts, rvalid held continuously.
  assign m_axi_arready = ar_rdy;
  assign s_addr        = s_base + 64'(s_beat) * 64'd8;
  assign m_axi_rdata   = {memf(s_addr + 64'd4), memf(s_addr)};
  assign m_axi_rlast   = (s_beat == 8'd7);
  assign m_axi_rresp   = (int'(s_beat) == err_beat) ? 2'b10 : 2'b00;

  always @(posedge clk) begin
    if (reset) begin
      m_axi_rvalid <= 1'b0;
      s_beat       <= 8'd0;
      s_base       <= 64'd0;
    end else begin
      if (m_axi_rvalid && m_axi_rready) begin
        if (s_beat == 8'd7) begin
          m_axi_rvalid <= 1'b0;
          s_beat       <= 8'd0;
        end else begin
          s_beat <= s_beat + 8'd1;
        end
      end
      if (m_axi_arvalid && m_axi_arready) begin
        m_axi_rvalid <= 1'b1;
        s_base       <= m_axi_araddr;
        s_beat       <= 8'd0;
      end
    end
  end

  // Record AR handshakes and accepted instructions.
  always @(negedge clk) begin
    if (!reset) begin
      if (m_axi_arvalid && m_axi_arready) ar_q.push_back(m_axi_araddr);
      if (inst_valid && inst_ready && !redirect_valid) begin
        pc_q.push_back(inst_pc);
        in_q.push_back(inst);
      end
    end
  end

  task automatic do_reset(input logic [63:0] e);
    entry = e;
    redirect_valid = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    ar_q.delete();
    pc_q.delete();
    in_q.delete();
    reset = 1'b0;
  endtask

  task automatic wait_pcs(input int n);
    int k = 0;
    while (pc_q.size() < n && k < 300) begin
      @(posedge clk);
      #1;
      k++;
    end
  endtask

  task automatic wait_ars(input int n);
    int k = 0;
    while (ar_q.size() < n && k < 300) begin
      @(posedge clk);
      #1;
      k++;
    end
  endtask

  task automatic test_reset();
    entry = 64'h8000_0004;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (m_axi_arvalid !== 1'b0 || m_axi_rready !== 1'b0) begin
      errors++;
      $display("FAIL reset_axi: arvalid=%b rready=%b expected 0 0",
               m_axi_arvalid, m_axi_rready);
    end
    checks++;
    if (inst_valid !== 1'b0 || fetch_fault !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: inst_valid=%b fault=%b expected 0 0",
               inst_valid, fetch_fault);
    end
    checks++;
    if (m_axi_araddr !== 64'h0 || inst !== 32'h0 || inst_pc !== 64'h0) begin
      errors++;
      $display("FAIL reset_data: araddr=%h inst=%h pc=%h expected 0",
               m_axi_araddr, inst, inst_pc);
    end
    ar_q.delete();
    pc_q.delete();
    in_q.delete();
    reset = 1'b0;
    checks++;
    if (m_axi_arvalid !== 1'b0) begin
      errors++;
      $display("FAIL idle_first_cycle: arvalid=%b expected 0", m_axi_arvalid);
    end
    @(posedge clk);
    #1;
    checks++;
    if (m_axi_arvalid !== 1'b1 || m_axi_araddr !== 64'h8000_0000) begin
      errors++;
      $display("FAIL first_ar: arvalid=%b araddr=%h expected 1 80000000",
               m_axi_arvalid, m_axi_araddr);
    end
    checks++;
    if (m_axi_arlen !== 8'd7 || m_axi_arsize !== 3'd3 ||
        m_axi_arburst !== 2'b01 || m_axi_arid !== 13'd0) begin
      errors++;
      $display("FAIL ar_attr: len=%0d size=%0d burst=%0d id=%0d expected 7 3 1 0",
               m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arid);
    end
  endtask

  task automatic test_cold_start();
    wait_pcs(15);
    checks++;
    if (pc_q.size() < 15) begin
      errors++;
      $display("FAIL cold_count: got %0d insts expected >=15", pc_q.size());
    end else begin
      checks++;
      if (pc_q[0] !== 64'h8000_0004 || in_q[0] !== memf(64'h8000_0004)) begin
        errors++;
        $display("FAIL cold_first: pc=%h inst=%h expected pc 80000004",
                 pc_q[0], in_q[0]);
      end
      checks++;
      if (pc_q[14] !== 64'h8000_003C || in_q[14] !== memf(64'h8000_003C)) begin
        errors++;
        $display("FAIL cold_last: pc=%h inst=%h expected pc 8000003c",
                 pc_q[14], in_q[14]);
      end
    end
    wait_ars(2);
    checks++;
    if (ar_q.size() < 2) begin
      errors++;
      $display("FAIL cold_ar_count: got %0d expected >=2", ar_q.size());
    end else begin
      checks++;
      if (ar_q[0] !== 64'h8000_0000 || ar_q[1] !== 64'h8000_0040) begin
        errors++;
        $display("FAIL cold_ar_addr: got %h %h expected 80000000 80000040",
                 ar_q[0], ar_q[1]);
      end
    end
  endtask

  task automatic test_backpressure();
    inst_ready = 1'b0;
    do_reset(64'h8000_0004);
    repeat (200) @(posedge clk);
    #1;
    checks++;
    if (ar_q.size() != 2) begin
      errors++;
      $display("FAIL bp_ar_count: got %0d expected 2", ar_q.size());
    end else begin
      checks++;
      if (ar_q[1] !== 64'h8000_0040) begin
        errors++;
        $display("FAIL bp_ar_second: got %h expected 80000040", ar_q[1]);
      end
    end
    checks++;
    if (m_axi_arvalid !== 1'b0 || inst_valid !== 1'b1) begin
      errors++;
      $display("FAIL bp_stall: arvalid=%b inst_valid=%b expected 0 1",
               m_axi_arvalid, inst_valid);
    end
    inst_ready = 1'b1;
    wait_pcs(31);
    checks++;
    if (pc_q.size() < 31) begin
      errors++;
      $display("FAIL bp_release_count: got %0d expected >=31", pc_q.size());
    end else begin
      for (int i = 0; i < 31; i++) begin
        checks++;
        if (pc_q[i] !== 64'h8000_0004 + 64'(4 * i) ||
            in_q[i] !== memf(64'h8000_0004 + 64'(4 * i))) begin
          errors++;
          $display("FAIL bp_seq[%0d]: pc=%h inst=%h expected pc %h",
                   i, pc_q[i], in_q[i], 64'h8000_0004 + 64'(4 * i));
        end
      end
    end
  endtask

  task automatic test_redirect_mid();
    int k = 0;
    int mark_pc;
    int mark_ar;
    do_reset(64'h8000_0000);
    while (!(m_axi_rvalid && s_beat == 8'd3) && k < 100) begin
      @(posedge clk);
      #1;
      k++;
    end
    checks++;
    if (!(m_axi_rvalid && s_beat == 8'd3)) begin
      errors++;
      $display("FAIL redir_wait_beat3: rvalid=%b beat=%0d expected 1 3",
               m_axi_rvalid, s_beat);
    end
    redirect_valid = 1'b1;
    redirect_pc = 64'h8000_100B;
    mark_pc = pc_q.size();
    mark_ar = ar_q.size();
    @(posedge clk);
    #1;
    redirect_valid = 1'b0;
    checks++;
    if (inst_valid !== 1'b0 || m_axi_rready !== 1'b1) begin
      errors++;
      $display("FAIL redir_flush: inst_valid=%b rready=%b expected 0 1",
               inst_valid, m_axi_rready);
    end
    wait_ars(mark_ar + 1);
    checks++;
    if (ar_q.size() < mark_ar + 1) begin
      errors++;
      $display("FAIL redir_ar: no AR after redirect expected 80001000");
    end else if (ar_q[mark_ar] !== 64'h8000_1000) begin
      errors++;
      $display("FAIL redir_ar: got %h expected 80001000", ar_q[mark_ar]);
    end
    wait_pcs(mark_pc + 14);
    checks++;
    if (pc_q.size() < mark_pc + 14) begin
      errors++;
      $display("FAIL redir_count: got %0d expected >=%0d",
               pc_q.size(), mark_pc + 14);
    end else begin
      for (int i = 0; i < 14; i++) begin
        checks++;
        if (pc_q[mark_pc + i] !== 64'h8000_1008 + 64'(4 * i) ||
            in_q[mark_pc + i] !== memf(64'h8000_1008 + 64'(4 * i))) begin
          errors++;
          $display("FAIL redir_seq[%0d]: pc=%h expected %h", i,
                   pc_q[mark_pc + i], 64'h8000_1008 + 64'(4 * i));
        end
      end
    end
  endtask

  task automatic test_ar_hold();
    int k = 0;
    ar_rdy = 1'b0;
    do_reset(64'h8000_0000);
    while (!m_axi_arvalid && k < 20) begin
      @(posedge clk);
      #1;
      k++;
    end
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (m_axi_arvalid !== 1'b1 || m_axi_araddr !== 64'h8000_0000) begin
        errors++;
        $display("FAIL hold_ar[%0d]: arvalid=%b araddr=%h expected 1 80000000",
                 c, m_axi_arvalid, m_axi_araddr);
      end
      redirect_valid = (c == 1);
      redirect_pc = 64'h8000_2000;
      @(posedge clk);
      #1;
    end
    redirect_valid = 1'b0;
    ar_rdy = 1'b1;
    wait_ars(2);
    checks++;
    if (ar_q.size() < 2) begin
      errors++;
      $display("FAIL hold_ar_count: got %0d expected >=2", ar_q.size());
    end else if (ar_q[0] !== 64'h8000_0000 || ar_q[1] !== 64'h8000_2000) begin
      errors++;
      $display("FAIL hold_ar_seq: got %h %h expected 80000000 80002000",
               ar_q[0], ar_q[1]);
    end
    wait_pcs(1);
    checks++;
    if (pc_q.size() < 1) begin
      errors++;
      $display("FAIL hold_first_pc: none expected 80002000");
    end else if (pc_q[0] !== 64'h8000_2000) begin
      errors++;
      $display("FAIL hold_first_pc: got %h expected 80002000", pc_q[0]);
    end
  endtask

  task automatic test_slverr();
    err_beat = 2;
    do_reset(64'h8000_0000);
    repeat (60) @(posedge clk);
    #1;
    checks++;
    if (pc_q.size() != 4) begin
      errors++;
      $display("FAIL err_count: got %0d insts expected 4", pc_q.size());
    end else if (pc_q[3] !== 64'h8000_000C) begin
      errors++;
      $display("FAIL err_last_pc: got %h expected 8000000c", pc_q[3]);
    end
    checks++;
    if (fetch_fault !== 1'b1 || ar_q.size() != 1) begin
      errors++;
      $display("FAIL err_stall: fault=%b ars=%0d expected 1 1",
               fetch_fault, ar_q.size());
    end
    err_beat = -1;
    redirect_valid = 1'b1;
    redirect_pc = 64'h8000_3000;
    @(posedge clk);
    #1;
    redirect_valid = 1'b0;
    checks++;
    if (fetch_fault !== 1'b0) begin
      errors++;
      $display("FAIL err_clear: fault=%b expected 0", fetch_fault);
    end
    wait_pcs(5);
    checks++;
    if (pc_q.size() < 5 || ar_q.size() < 2) begin
      errors++;
      $display("FAIL err_resume: insts=%0d ars=%0d expected >=5 >=2",
               pc_q.size(), ar_q.size());
    end else if (pc_q[4] !== 64'h8000_3000 || ar_q[1] !== 64'h8000_3000) begin
      errors++;
      $display("FAIL err_resume_addr: pc=%h ar=%h expected 80003000",
               pc_q[4], ar_q[1]);
    end
  endtask

  task automatic test_reset_mid();
    int k = 0;
    do_reset(64'h8000_0000);
    while (!(m_axi_rvalid && s_beat == 8'd3) && k < 100) begin
      @(posedge clk);
      #1;
      k++;
    end
    entry = 64'h8000_4000;
    reset = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (m_axi_arvalid !== 1'b0 || m_axi_rready !== 1'b0 ||
        inst_valid !== 1'b0 || fetch_fault !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_flags: arv=%b rr=%b iv=%b ff=%b expected 0",
               m_axi_arvalid, m_axi_rready, inst_valid, fetch_fault);
    end
    checks++;
    if (m_axi_araddr !== 64'h0 || inst !== 32'h0 || inst_pc !== 64'h0) begin
      errors++;
      $display("FAIL rst_mid_data: araddr=%h inst=%h pc=%h expected 0",
               m_axi_araddr, inst, inst_pc);
    end
    @(posedge clk);
    #1;
    ar_q.delete();
    pc_q.delete();
    in_q.delete();
    reset = 1'b0;
    wait_pcs(1);
    checks++;
    if (pc_q.size() < 1 || ar_q.size() < 1) begin
      errors++;
      $display("FAIL rst_mid_restart: insts=%0d ars=%0d expected >=1",
               pc_q.size(), ar_q.size());
    end else if (ar_q[0] !== 64'h8000_4000 || pc_q[0] !== 64'h8000_4000) begin
      errors++;
      $display("FAIL rst_mid_addr: ar=%h pc=%h expected 80004000",
               ar_q[0], pc_q[0]);
    end
  endtask

  initial begin
    test_reset();
    test_cold_start();
    test_backpressure();
    test_redirect_mid();
    test_ar_hold();
    test_slverr();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
